pdm_cic_source: RTL and testbench

- Front end of the PDM microphone path.
- Generates the microphone bit clock, samples the 1-bit PDM stream, and decimates it with an N-stage CIC filter.
- Emits signed 16-bit PCM samples on a valid/ready/payload stream, the producer side of the FIR engine's io_data_in stream.
- Output stream connects directly to FirEngine io_data_in_*.

---
 rtl/pdm_cic_source_if.sv | 17 +
 rtl/pdm_cic_source.sv | 234 +++++++++++++++++++++++
 tb/tb_pdm_cic_source.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_cic_source_if.sv
// ---------------------------------------------------------------------------
// pdm_cic_source_if
// Valid/ready/payload stream carrying signed 16-bit PCM samples from the
// PDM CIC front end to the FIR engine input.
//   valid   : producer has a sample on payload
//   ready   : consumer accepts the sample this cycle
//   payload : signed 16-bit PCM sample
// master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pdm_cic_source_if;
  logic        valid;
  logic        ready;
  logic [15:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pdm_cic_source.sv
// ---------------------------------------------------------------------------
// pdm_cic_source
// PDM microphone front end: generates the microphone bit clock, samples the
// 1-bit PDM stream once per bit and decimates it with an N-stage CIC filter
// (differential delay 1). Results are shifted, saturated to 16 bits and
// presented on a valid/ready stream.
//
// Ports:
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   io_enable   : run enable; low clears the filter and stops the bit clock
//   io_pdm_clk  : microphone bit clock (CLK_DIV clk per period, 50% duty)
//   io_pdm_dat  : PDM data, 1 => +1, 0 => -1
//   io_data_out : PCM sample stream (master side)
//   io_overrun  : sticky flag, a decimated sample was dropped under backpressure
// ---------------------------------------------------------------------------
module pdm_cic_source #(
  parameter int CLK_DIV   = 4,
  parameter int DECIM     = 12,
  parameter int STAGES    = 4,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_enable,
  output logic                      io_pdm_clk,
  input  logic                      io_pdm_dat,
  pdm_cic_source_if.master          io_data_out,
  output logic                      io_overrun
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int DW   = $clog2(DECIM);
  localparam int WW   = $clog2(STAGES + 1);
  // Saturation compare width: at least 17 bits so the 16-bit limits are representable.
  localparam int SW   = (ACC_W > 17) ? ACC_W : 17;

  localparam logic [CW-1:0]        C_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]        C_STROBE = CW'(HALF - 1);
  localparam logic [CW-1:0]        C_HALF   = CW'(HALF);
  localparam logic [DW-1:0]        D_LAST   = DW'(DECIM - 1);
  localparam logic [WW-1:0]        W_DONE   = WW'(STAGES);
  localparam logic signed [SW-1:0] SAT_HI   = SW'(32'sd32767);
  localparam logic signed [SW-1:0] SAT_LO   = SW'(-32'sd32768);

  // Clamp a signed value to the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [SW-1:0] v);
    logic [15:0] r;
    if (v > SAT_HI) begin
      r = 16'h7FFF;
    end else if (v < SAT_LO) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  logic [CW-1:0]        c_q, c_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic [DW-1:0]        d_q, d_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [ACC_W-1:0]     integ_q [STAGES];
  logic [ACC_W-1:0]     integ_d [STAGES];
  logic [ACC_W-1:0]     dly_q   [STAGES];
  logic [ACC_W-1:0]     dly_d   [STAGES];
  logic [ACC_W-1:0]     comb_s  [STAGES+1];
  logic                 valid_q, valid_d;
  logic [15:0]          payload_q, payload_d;
  logic                 overrun_q, overrun_d;

  logic                 strobe_s;
  logic                 dec_s;
  logic                 present_s;
  logic                 xfer_s;
  logic [ACC_W-1:0]     x_s;
  logic signed [ACC_W-1:0] shift_s;
  logic [15:0]          sample_s;

  // Bit-clock divider and per-bit sample strobe.
  always_comb begin
    c_d       = '0;
    pdm_clk_d = 1'b0;
    strobe_s  = 1'b0;
    if (io_enable) begin
      strobe_s = (c_q == C_STROBE);
      if (c_q == C_LAST) begin
        c_d = '0;
      end else begin
        c_d = c_q + CW'(1);
      end
      // Registered from the next count so io_pdm_clk tracks c without glitches.
      pdm_clk_d = (c_d < C_HALF);
    end else begin
      c_d       = '0;
      pdm_clk_d = 1'b0;
    end
  end

  // PDM bit mapped to +1 / -1 at accumulator width.
  always_comb begin
    x_s = '0;
    if (io_pdm_dat) begin
      x_s = ACC_W'(1);
    end else begin
      x_s = {ACC_W{1'b1}};
    end
  end

  // Decimation counter and warm-up counter.
  always_comb begin
    dec_s     = strobe_s && (d_q == D_LAST);
    present_s = dec_s && (warm_q == W_DONE);
    d_d       = d_q;
    warm_d    = warm_q;
    if (!io_enable) begin
      d_d    = '0;
      warm_d = '0;
    end else begin
      if (strobe_s) begin
        if (dec_s) begin
          d_d = '0;
        end else begin
          d_d = d_q + DW'(1);
        end
      end else begin
        d_d = d_q;
      end
      // The first STAGES results still carry start-up transients; count them off.
      if (dec_s && (warm_q != W_DONE)) begin
        warm_d = warm_q + WW'(1);
      end else begin
        warm_d = warm_q;
      end
    end
  end

  // Integrator chain and comb chain (modulo 2^ACC_W, wrap intended).
  always_comb begin
    comb_s[0] = integ_q[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      comb_s[k+1] = comb_s[k] - dly_q[k];
    end
    integ_d = integ_q;
    dly_d   = dly_q;
    if (!io_enable) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[k] = '0;
        dly_d[k]   = '0;
      end
    end else begin
      if (strobe_s) begin
        // Each stage adds the previous stage's registered value.
        integ_d[0] = integ_q[0] + x_s;
        for (int k = 1; k < STAGES; k++) begin
          integ_d[k] = integ_q[k] + integ_q[k-1];
        end
      end else begin
        integ_d = integ_q;
      end
      if (dec_s) begin
        for (int k = 0; k < STAGES; k++) begin
          dly_d[k] = comb_s[k];
        end
      end else begin
        dly_d = dly_q;
      end
    end
  end

  // Output scaling and saturation of the final comb result.
  always_comb begin
    shift_s  = $signed(comb_s[STAGES]) >>> OUT_SHIFT;
    sample_s = sat16(SW'(shift_s));
  end

  // Output handshake: load, hold under backpressure, drop with overrun.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    overrun_d = overrun_q;
    xfer_s    = valid_q && io_data_out.ready;
    if (present_s) begin
      // A transfer in the same cycle frees the register for the new sample.
      if (!valid_q || io_data_out.ready) begin
        valid_d   = 1'b1;
        payload_d = sample_s;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q       <= '0;
      pdm_clk_q <= 1'b0;
      d_q       <= '0;
      warm_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      valid_q   <= 1'b0;
      payload_q <= 16'h0000;
      overrun_q <= 1'b0;
    end else begin
      c_q       <= c_d;
      pdm_clk_q <= pdm_clk_d;
      d_q       <= d_d;
      warm_q    <= warm_d;
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      valid_q   <= valid_d;
      payload_q <= payload_d;
      overrun_q <= overrun_d;
    end
  end

  assign io_pdm_clk          = pdm_clk_q;
  assign io_data_out.valid   = valid_q;
  assign io_data_out.payload = payload_q;
  assign io_overrun          = overrun_q;

endmodule

// File: tb/tb_pdm_cic_source.sv
// ---------------------------------------------------------------------------
// tb_pdm_cic_source
// Directed bench for pdm_cic_source. A default-parameter instance exercises
// timing, filtering, handshake, enable and reset; two DECIM=16 instances
// (OUT_SHIFT 0 and 2) cover saturation and output shifting.
// ---------------------------------------------------------------------------
module tb_pdm_cic_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic enable;
  logic pdm_dat;
  logic pdm_clk;
  logic overrun;
  logic sat_dat;
  logic sat_pclk, sat_ovr;
  logic shf_pclk, shf_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int alt_cnt  = 0;
  bit alt_mode = 1'b0;
  int n;

  pdm_cic_source_if dout ();
  pdm_cic_source_if sat_if ();
  pdm_cic_source_if shf_if ();

  pdm_cic_source dut (
    .clk         (clk),
    .reset       (rst_n),
    .io_enable   (enable),
    .io_pdm_clk  (pdm_clk),
    .io_pdm_dat  (pdm_dat),
    .io_data_out (dout.master),
    .io_overrun  (overrun)
  );

  pdm_cic_source #(.DECIM(16), .STAGES(4), .ACC_W(24), .OUT_SHIFT(0)) dut_sat (
    .clk         (clk),
    .reset       (rst_n),
    .io_enable   (1'b1),
    .io_pdm_clk  (sat_pclk),
    .io_pdm_dat  (sat_dat),
    .io_data_out (sat_if.master),
    .io_overrun  (sat_ovr)
  );

  pdm_cic_source #(.DECIM(16), .STAGES(4), .ACC_W(24), .OUT_SHIFT(2)) dut_shf (
    .clk         (clk),
    .reset       (rst_n),
    .io_enable   (1'b1),
    .io_pdm_clk  (shf_pclk),
    .io_pdm_dat  (sat_dat),
    .io_data_out (shf_if.master),
    .io_overrun  (shf_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; when alternating, the data flips every 4 clk (once per PDM bit).
  task automatic tick();
    @(posedge clk);
    #1;
    if (alt_mode) begin
      alt_cnt++;
      pdm_dat = alt_cnt[2];
    end
  endtask

  // Advance until valid is seen; ncyc = clocks taken.
  task automatic wait_valid(output int ncyc);
    bit found;
    found = 1'b0;
    ncyc  = 0;
    while (!found && ncyc < 400) begin
      tick();
      ncyc++;
      if (dout.valid === 1'b1) found = 1'b1;
    end
    check("valid_timeout", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_samples(input int k);
    int t;
    for (int i = 0; i < k; i++) begin
      wait_valid(t);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    pdm_dat    = 1'b1;
    sat_dat    = 1'b1;
    dout.ready   = 1'b1;
    sat_if.ready = 1'b1;
    shf_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pdm_clk", {31'b0, pdm_clk}, 32'd0);
    check("rst_valid",   {31'b0, dout.valid}, 32'd0);
    check("rst_payload", {16'h0, dout.payload}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);

    // Constant ones: bit clock shape, warm-up latency, rate, gain.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("pdm_clk_pattern", {31'b0, pdm_clk}, {31'b0, ((i % 4) < 2)});
      check("no_valid_early", {31'b0, dout.valid}, 32'd0);
    end
    wait_valid(n);
    check("first_valid_cycle", n + 8, 32'd238);
    check("ones_payload_1", {16'h0, dout.payload}, 32'h5100);
    tick();
    check("valid_pulse_falls", {31'b0, dout.valid}, 32'd0);
    wait_valid(n);
    check("sample_interval", n, 32'd47);
    check("ones_payload_2", {16'h0, dout.payload}, 32'h5100);

    // Ready raised exactly on the cycle the next sample loads.
    dout.ready = 1'b0;
    repeat (47) tick();
    dout.ready = 1'b1;
    tick();
    check("simul_valid_stays", {31'b0, dout.valid}, 32'd1);
    check("simul_no_overrun", {31'b0, overrun}, 32'd0);
    check("simul_payload", {16'h0, dout.payload}, 32'h5100);
    tick();
    check("simul_valid_falls", {31'b0, dout.valid}, 32'd0);

    // Saturation instances have seen constant ones for > 5 decimations of 64 clk.
    check("sat_pos", {16'h0, sat_if.payload}, 32'h7FFF);
    check("shift_pos", {16'h0, shf_if.payload}, 32'h4000);
    sat_dat = 1'b0;

    // Constant zeros: -20736.
    pdm_dat = 1'b0;
    wait_samples(6);
    check("zeros_payload", {16'h0, dout.payload}, 32'hAF00);

    // Alternating bits: 0.
    alt_mode = 1'b1;
    wait_samples(6);
    check("alt_payload", {16'h0, dout.payload}, 32'h0000);
    alt_mode = 1'b0;
    pdm_dat  = 1'b1;
    wait_samples(6);
    check("ones_again", {16'h0, dout.payload}, 32'h5100);
    check("sat_neg", {16'h0, sat_if.payload}, 32'h8000);
    check("shift_neg", {16'h0, shf_if.payload}, 32'hC000);
    check("sat_no_overrun", {31'b0, sat_ovr}, 32'd0);

    // Backpressure across two decimation points.
    tick();
    dout.ready = 1'b0;
    wait_valid(n);
    check("bp_first", {16'h0, dout.payload}, 32'h5100);
    check("bp_overrun_before", {31'b0, overrun}, 32'd0);
    pdm_dat = 1'b0;
    repeat (60) tick();
    check("bp_valid_held", {31'b0, dout.valid}, 32'd1);
    check("bp_payload_held", {16'h0, dout.payload}, 32'h5100);
    check("bp_overrun_set", {31'b0, overrun}, 32'd1);
    dout.ready = 1'b1;
    tick();
    check("bp_valid_falls", {31'b0, dout.valid}, 32'd0);
    check("bp_overrun_sticky", {31'b0, overrun}, 32'd1);

    // Enable dropped with an unaccepted sample.
    pdm_dat = 1'b1;
    wait_samples(6);
    check("en_pre_payload", {16'h0, dout.payload}, 32'h5100);
    tick();
    dout.ready = 1'b0;
    wait_valid(n);
    enable = 1'b0;
    repeat (3) tick();
    check("en_pdm_clk_low", {31'b0, pdm_clk}, 32'd0);
    check("en_valid_held", {31'b0, dout.valid}, 32'd1);
    check("en_payload_held", {16'h0, dout.payload}, 32'h5100);
    check("en_overrun_kept", {31'b0, overrun}, 32'd1);
    dout.ready = 1'b1;
    tick();
    check("en_valid_falls", {31'b0, dout.valid}, 32'd0);
    enable = 1'b1;
    wait_valid(n);
    check("reen_first_valid", n, 32'd238);
    check("reen_payload", {16'h0, dout.payload}, 32'h5100);

    // Asynchronous reset in the middle of a high bit-clock phase.
    n = 0;
    while (pdm_clk !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("pdm_clk_high_seen", {31'b0, pdm_clk}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pdm_clk", {31'b0, pdm_clk}, 32'd0);
    check("arst_valid", {31'b0, dout.valid}, 32'd0);
    check("arst_payload", {16'h0, dout.payload}, 32'h0);
    check("arst_overrun", {31'b0, overrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
